// File: rtl/multi_line_buffer.sv
// multi_line_buffer: fully-associative write-back buffer between a core SRAMx
// port and the cache bus. Holds NUM_LINES lines of LINE_WORDS 32-bit words.
// Hits complete in the request cycle. A miss writes back a dirty victim, then
// refills the line and forwards the critical word. Victims are picked round-robin.
// flush_req writes back every dirty line, then invalidates the whole buffer.
//
// Ports:
//   clk, reset   clock; synchronous active-high reset
//   sramx_req    core request  (req, wr, size, addr, wdata)
//   sramx_resp   core response (addr_ok, data_ok, rdata)
//   cbus_req     bus request   (valid, is_write, order, addr, wdata)
//   cbus_resp    bus response  (okay, last, rdata)
//   flush_req    level input; only looked at in IDLE
//   flush_done   one-cycle pulse after a flush completes

package mlb_pkg;

   typedef struct packed {
      logic        req;
      logic        wr;
      logic [1:0]  size;    // 0 byte, 1 halfword, 2 word
      logic [31:0] addr;
      logic [31:0] wdata;   // byte lanes already aligned to addr[1:0]
   } sramx_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] rdata;
   } sramx_resp_t;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [3:0]  order;   // log2 of the burst length
      logic [31:0] addr;
      logic [31:0] wdata;
   } cbus_req_t;

   typedef struct packed {
      logic        okay;
      logic        last;
      logic [31:0] rdata;
   } cbus_resp_t;

   typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_REFILL, S_FLUSH} state_e;

   function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] align);
      case (size)
         2'd0:    return 4'b0001 << align;
         2'd1:    return 4'b0011 << align;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] strb);
      logic [31:0] res;
      res = old_w;
      for (int b = 0; b < 4; b++)
         if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
      return res;
   endfunction

endpackage

module multi_line_buffer
   import mlb_pkg::*;
#(
   parameter int NUM_LINES  = 4,
   parameter int LINE_WORDS = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  sramx_req_t  sramx_req,
   output sramx_resp_t sramx_resp,
   output cbus_req_t   cbus_req,
   input  cbus_resp_t  cbus_resp,
   input  logic        flush_req,
   output logic        flush_done
);

   localparam int OB = $clog2(LINE_WORDS);
   localparam int VB = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
   localparam int TW = 30 - OB;

   state_e                 state_q, state_d;
   logic [NUM_LINES-1:0]   valid_q, valid_d, dirty_q, dirty_d;
   logic [TW-1:0]          tag_q  [NUM_LINES];
   logic [31:0]            data_q [NUM_LINES][LINE_WORDS];
   logic [VB-1:0]          victim_q, victim_d, scan_q, scan_d;
   logic [OB-1:0]          cnt_q, cnt_d;
   logic                   flushing_q, flushing_d;
   logic                   flush_done_q, flush_done_d;
   logic                   saved_wr_q, saved_wr_d;
   logic [1:0]             saved_size_q, saved_size_d;
   logic [31:0]            saved_addr_q, saved_addr_d;
   logic [31:0]            saved_wdata_q, saved_wdata_d;

   // Single write port into line storage and tags
   logic                   mem_we, tag_we;
   logic [VB-1:0]          mem_idx;
   logic [OB-1:0]          mem_off;
   logic [31:0]            mem_wdata;

   logic [TW-1:0]          req_tag, saved_tag;
   logic [OB-1:0]          req_off, saved_off;
   logic                   hit;
   logic [VB-1:0]          hit_idx, wb_idx;

   assign req_tag   = sramx_req.addr[31:OB+2];
   assign req_off   = sramx_req.addr[OB+1:2];
   assign saved_tag = saved_addr_q[31:OB+2];
   assign saved_off = saved_addr_q[OB+1:2];
   // A write-back burst drains the victim on a miss, or the scanned line during a flush
   assign wb_idx    = flushing_q ? scan_q : victim_q;
   assign flush_done = flush_done_q;

   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < NUM_LINES; i++) begin
         if (valid_q[i] && (tag_q[i] == req_tag)) begin
            hit     = 1'b1;
            hit_idx = VB'(i);
         end
      end
   end

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
      state_d       = state_q;
      valid_d       = valid_q;
      dirty_d       = dirty_q;
      victim_d      = victim_q;
      scan_d        = scan_q;
      cnt_d         = cnt_q;
      flushing_d    = flushing_q;
      flush_done_d  = 1'b0;
      saved_wr_d    = saved_wr_q;
      saved_size_d  = saved_size_q;
      saved_addr_d  = saved_addr_q;
      saved_wdata_d = saved_wdata_q;
      sramx_resp    = '0;
      cbus_req      = '0;
      cbus_req.order = 4'(OB);
      mem_we        = 1'b0;
      tag_we        = 1'b0;
      mem_idx       = victim_q;
      mem_off       = cnt_q;
      mem_wdata     = cbus_resp.rdata;

      case (state_q)
         S_IDLE: begin
            // A pending flush takes priority and refuses any same-cycle request
            sramx_resp.addr_ok = !flush_req;
            if (flush_req) begin
               state_d    = S_FLUSH;
               scan_d     = '0;
               flushing_d = 1'b1;
            end else if (sramx_req.req) begin
               if (hit) begin
                  sramx_resp.data_ok = 1'b1;
                  sramx_resp.rdata   = data_q[hit_idx][req_off];
                  if (sramx_req.wr) begin
                     mem_we    = 1'b1;
                     mem_idx   = hit_idx;
                     mem_off   = req_off;
                     mem_wdata = merge_bytes(data_q[hit_idx][req_off], sramx_req.wdata,
                                             byte_strobe(sramx_req.size, sramx_req.addr[1:0]));
                     dirty_d[hit_idx] = 1'b1;
                  end
               end else begin
                  saved_wr_d    = sramx_req.wr;
                  saved_size_d  = sramx_req.size;
                  saved_addr_d  = sramx_req.addr;
                  saved_wdata_d = sramx_req.wdata;
                  cnt_d         = '0;
                  flushing_d    = 1'b0;
                  state_d = (valid_q[victim_q] && dirty_q[victim_q]) ? S_WRITEBACK : S_REFILL;
               end
            end
         end

         S_WRITEBACK: begin
            cbus_req.valid    = 1'b1;
            cbus_req.is_write = 1'b1;
            cbus_req.addr     = {tag_q[wb_idx], {(OB+2){1'b0}}};
            cbus_req.wdata    = data_q[wb_idx][cnt_q];
            if (cbus_resp.okay) begin
               cnt_d = cnt_q + 1'b1;   // wraps to zero on the final beat
               if (cbus_resp.last) begin
                  dirty_d[wb_idx] = 1'b0;
                  state_d = flushing_q ? S_FLUSH : S_REFILL;
               end
            end
         end

         S_REFILL: begin
            cbus_req.valid = 1'b1;
            cbus_req.addr  = {saved_tag, {(OB+2){1'b0}}};
            if (cbus_resp.okay) begin
               mem_we = 1'b1;
               if (cnt_q == saved_off) begin
                  // Critical word: merge a pending store and forward the raw bus word
                  if (saved_wr_q)
                     mem_wdata = merge_bytes(cbus_resp.rdata, saved_wdata_q,
                                             byte_strobe(saved_size_q, saved_addr_q[1:0]));
                  sramx_resp.data_ok = 1'b1;
                  sramx_resp.rdata   = cbus_resp.rdata;
               end
               cnt_d = cnt_q + 1'b1;
               if (cbus_resp.last) begin
                  valid_d[victim_q] = 1'b1;
                  dirty_d[victim_q] = saved_wr_q;
                  tag_we            = 1'b1;
                  victim_d = (victim_q == VB'(NUM_LINES - 1)) ? '0 : victim_q + 1'b1;
                  state_d  = S_IDLE;
               end
            end
         end

         S_FLUSH: begin
            // A line just written back is clean on return, so the scan then moves on
            if (valid_q[scan_q] && dirty_q[scan_q]) begin
               cnt_d   = '0;
               state_d = S_WRITEBACK;
            end else if (scan_q == VB'(NUM_LINES - 1)) begin
               valid_d      = '0;
               flush_done_d = 1'b1;
               flushing_d   = 1'b0;
               state_d      = S_IDLE;
            end else begin
               scan_d = scan_q + 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         valid_q       <= '0;
         dirty_q       <= '0;
         victim_q      <= '0;
         scan_q        <= '0;
         cnt_q         <= '0;
         flushing_q    <= 1'b0;
         flush_done_q  <= 1'b0;
         saved_wr_q    <= 1'b0;
         saved_size_q  <= '0;
         saved_addr_q  <= '0;
         saved_wdata_q <= '0;
      end else begin
         state_q       <= state_d;
         valid_q       <= valid_d;
         dirty_q       <= dirty_d;
         victim_q      <= victim_d;
         scan_q        <= scan_d;
         cnt_q         <= cnt_d;
         flushing_q    <= flushing_d;
         flush_done_q  <= flush_done_d;
         saved_wr_q    <= saved_wr_d;
         saved_size_q  <= saved_size_d;
         saved_addr_q  <= saved_addr_d;
         saved_wdata_q <= saved_wdata_d;
      end
   end

   // NOTE: line data and tags are not reset; the valid bits alone say whether their contents mean anything.
   always_ff @(posedge clk) begin
      if (mem_we) data_q[mem_idx][mem_off] <= mem_wdata;
      if (tag_we) tag_q[victim_q] <= saved_tag;
   end

endmodule

// File: tb/tb_multi_line_buffer.sv
// Self-checking bench for multi_line_buffer (defaults: 4 lines x 16 words).
// Stimulus pushes expected read data into a queue; a monitor pops it on each
// data_ok. A bus slave model serves bursts from a sparse memory, logs every
// completed burst and stalls one cycle in four.

module tb_multi_line_buffer;
   import mlb_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   sramx_req_t  sramx_req;
   sramx_resp_t sramx_resp;
   cbus_req_t   cbus_req;
   cbus_resp_t  cbus_resp;
   logic        flush_req;
   logic        flush_done;

   multi_line_buffer #(.NUM_LINES(4), .LINE_WORDS(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .sramx_req  (sramx_req),
      .sramx_resp (sramx_resp),
      .cbus_req   (cbus_req),
      .cbus_resp  (cbus_resp),
      .flush_req  (flush_req),
      .flush_done (flush_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        chk;
      logic [31:0] data;
      string       name;
   } exp_t;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
   } burst_t;

   exp_t        exp_q[$];
   burst_t      burst_q[$];
   bit   [31:0] bus_mem [bit [31:0]];
   int          n_checks = 0;
   int          n_errors = 0;
   int          flush_pulses = 0;
   int          valid_cycles = 0;
   int          drv_beat = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Backing memory: 0x3xxx reads as zero, elsewhere each word is addr ^ 0x5A5A0000
   function automatic logic [31:0] bus_read(input logic [31:0] a);
      if (bus_mem.exists(a)) return bus_mem[a];
      return (a[15:12] == 4'h3) ? 32'h0 : (a ^ 32'h5A5A_0000);
   endfunction

   // Bus slave: one beat per non-stalled cycle while valid, last on beat 15
   initial begin
      int      beat = 0;
      int      cyc = 0;
      burst_t  cur;
      logic [31:0] a;
      cbus_resp = '0;
      cur = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         cbus_resp = '0;
         if (reset) begin
            beat = 0;
         end else if (cbus_req.valid) begin
            valid_cycles++;
            if ((cyc % 4) != 3) begin
               if (beat == 0) begin
                  cur.wr   = cbus_req.is_write;
                  cur.addr = cbus_req.addr;
               end else begin
                  check("burst_addr_stable", cbus_req.addr, cur.addr);
                  check("burst_dir_stable", 32'(cbus_req.is_write), 32'(cur.wr));
               end
               check("burst_order", 32'(cbus_req.order), 32'd4);
               a = cur.addr + 32'(beat * 4);
               if (cur.wr) bus_mem[a] = cbus_req.wdata;
               else        cbus_resp.rdata = bus_read(a);
               cbus_resp.okay = 1'b1;
               cbus_resp.last = (beat == 15);
               drv_beat = beat;
               if (beat == 15) begin
                  burst_q.push_back(cur);
                  beat = 0;
               end else begin
                  beat++;
               end
            end
         end
      end
   end

   // Monitor: one expected entry per data_ok, in issue order
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && sramx_resp.data_ok) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_data_ok: got rdata 0x%08h with nothing outstanding", sramx_resp.rdata);
            end else begin
               e = exp_q.pop_front();
               if (e.chk) check(e.name, sramx_resp.rdata, e.data);
            end
         end
         if (!reset && flush_done) flush_pulses++;
      end
   end

   // Issue one request (called at posedge+#1); optionally wait until it and any burst finish
   task automatic do_req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp, input string name,
                         input bit wait_done = 1'b1);
      exp_t e;
      bit   acc, done;
      e.chk = !wr;
      e.data = exp;
      e.name = name;
      exp_q.push_back(e);
      sramx_req = '{req: 1'b1, wr: wr, size: size, addr: addr, wdata: wdata};
      acc = 1'b0;
      for (int i = 0; i < 400 && !acc; i++) begin
         @(negedge clk);
         acc = sramx_resp.addr_ok;
      end
      check({name, "_accept"}, 32'(acc), 32'd1);
      @(posedge clk);
      #1;
      sramx_req.req = 1'b0;
      if (wait_done) begin
         done = 1'b0;
         for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !cbus_req.valid;
         end
         check({name, "_done"}, 32'(done), 32'd1);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_burst(input int idx, input logic wr, input logic [31:0] addr, input string name);
      if (idx < burst_q.size()) begin
         check({name, "_dir"}, 32'(burst_q[idx].wr), 32'(wr));
         check({name, "_addr"}, burst_q[idx].addr, addr);
      end else begin
         check({name, "_present"}, 32'(burst_q.size()), 32'(idx + 1));
      end
   endtask

   initial begin
      int  b0, v0;
      bit  found;
      reset     = 1'b1;
      flush_req = 1'b0;
      sramx_req = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cbus_valid", 32'(cbus_req.valid), 32'd0);
      check("rst_flush_done", 32'(flush_done), 32'd0);
      check("rst_data_ok", 32'(sramx_resp.data_ok), 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("idle_addr_ok", 32'(sramx_resp.addr_ok), 32'd1);

      // Cold read: refill 0x1000, word 2 forwarded
      b0 = burst_q.size();
      do_req(1'b0, 2'd2, 32'h0000_1008, 32'h0, 32'h5A5A_1008, "cold_read");
      check("cold_read_bursts", 32'(burst_q.size() - b0), 32'd1);
      check_burst(b0, 1'b0, 32'h0000_1000, "cold_refill");

      // Hit on the same line: no bus activity
      v0 = valid_cycles;
      do_req(1'b0, 2'd2, 32'h0000_100C, 32'h0, 32'h5A5A_100C, "hit_read");
      check("hit_no_bus", 32'(valid_cycles - v0), 32'd0);

      // Miss-write with merge into word 1
      b0 = burst_q.size();
      do_req(1'b1, 2'd2, 32'h0000_2004, 32'hDEAD_BEEF, 32'h0, "miss_write");
      check_burst(b0, 1'b0, 32'h0000_2000, "miss_write_refill");
      do_req(1'b0, 2'd2, 32'h0000_2004, 32'h0, 32'hDEAD_BEEF, "miss_write_readback");
      do_req(1'b0, 2'd2, 32'h0000_2008, 32'h0, 32'h5A5A_2008, "miss_write_neighbour");

      // Dirty 0x1000, fill the rest, fifth tag evicts 0x1000
      do_req(1'b1, 2'd2, 32'h0000_1010, 32'h1111_2222, 32'h0, "hit_write");
      do_req(1'b0, 2'd2, 32'h0000_3000, 32'h0, 32'h0000_0000, "fill_3000");
      do_req(1'b0, 2'd2, 32'h0000_4000, 32'h0, 32'h5A5A_4000, "fill_4000");
      b0 = burst_q.size();
      do_req(1'b0, 2'd2, 32'h0000_5000, 32'h0, 32'h5A5A_5000, "fill_5000");
      check("evict_bursts", 32'(burst_q.size() - b0), 32'd2);
      check_burst(b0,     1'b1, 32'h0000_1000, "evict_wb");
      check_burst(b0 + 1, 1'b0, 32'h0000_5000, "evict_refill");
      check("wb_1010", bus_read(32'h0000_1010), 32'h1111_2222);
      check("wb_1000", 32'(bus_mem.exists(32'h0000_1000)), 32'd1);
      check("wb_103c", bus_read(32'h0000_103C), 32'h5A5A_103C);

      // Victim is now line 1 (0x2000, dirty)
      b0 = burst_q.size();
      do_req(1'b0, 2'd2, 32'h0000_6000, 32'h0, 32'h5A5A_6000, "victim1_miss");
      check_burst(b0,     1'b1, 32'h0000_2000, "victim1_wb");
      check_burst(b0 + 1, 1'b0, 32'h0000_6000, "victim1_refill");
      check("wb_2004", bus_read(32'h0000_2004), 32'hDEAD_BEEF);

      // Dirty lines 1 (0x6000) and 3 (0x4000), then flush with a competing request
      do_req(1'b1, 2'd2, 32'h0000_6010, 32'h600D_F00D, 32'h0, "dirty_line1");
      do_req(1'b1, 2'd2, 32'h0000_4008, 32'hCAFE_F00D, 32'h0, "dirty_line3");
      b0 = burst_q.size();
      flush_req = 1'b1;
      sramx_req = '{req: 1'b1, wr: 1'b0, size: 2'd2, addr: 32'h0000_5000, wdata: 32'h0};
      @(negedge clk);
      check("flush_addr_ok", 32'(sramx_resp.addr_ok), 32'd0);
      check("flush_data_ok", 32'(sramx_resp.data_ok), 32'd0);
      @(posedge clk);
      #1;
      flush_req     = 1'b0;
      sramx_req.req = 1'b0;
      for (int i = 0; i < 400 && flush_pulses == 0; i++) @(negedge clk);
      repeat (4) @(negedge clk);
      check("flush_pulses", 32'(flush_pulses), 32'd1);
      check("flush_bursts", 32'(burst_q.size() - b0), 32'd2);
      check_burst(b0,     1'b1, 32'h0000_6000, "flush_wb0");
      check_burst(b0 + 1, 1'b1, 32'h0000_4000, "flush_wb1");
      check("flush_6010", bus_read(32'h0000_6010), 32'h600D_F00D);
      check("flush_4008", bus_read(32'h0000_4008), 32'hCAFE_F00D);
      @(posedge clk);
      #1;
      b0 = burst_q.size();
      do_req(1'b0, 2'd2, 32'h0000_5000, 32'h0, 32'h5A5A_5000, "post_flush_read");
      check("post_flush_miss", 32'(burst_q.size() - b0), 32'd1);

      // Byte store on a hit line over zero data
      do_req(1'b0, 2'd2, 32'h0000_3000, 32'h0, 32'h0000_0000, "fill_zero_line");
      v0 = valid_cycles;
      do_req(1'b1, 2'd0, 32'h0000_3002, 32'hABAB_ABAB, 32'h0, "sb_hit");
      do_req(1'b0, 2'd2, 32'h0000_3000, 32'h0, 32'h00AB_0000, "sb_readback");
      check("sb_no_bus", 32'(valid_cycles - v0), 32'd0);

      // Reset during beat 7 of a refill
      do_req(1'b0, 2'd2, 32'h0000_7008, 32'h0, 32'h5A5A_7008, "abort_read", 1'b0);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(posedge clk);
         #2;
         found = cbus_resp.okay && (drv_beat == 7);
      end
      check("abort_beat7_seen", 32'(found), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("abort_valid_drop", 32'(cbus_req.valid), 32'd0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;
      b0 = burst_q.size();
      do_req(1'b0, 2'd2, 32'h0000_7008, 32'h0, 32'h5A5A_7008, "reread", 1'b0);
      do_req(1'b0, 2'd2, 32'h0000_700C, 32'h0, 32'h5A5A_700C, "b2b_hit");
      check("reread_bursts", 32'(burst_q.size() - b0), 32'd1);
      check_burst(b0, 1'b0, 32'h0000_7000, "reread_refill");
      b0 = burst_q.size();
      do_req(1'b0, 2'd2, 32'h0000_3000, 32'h0, 32'h0000_0000, "lost_dirty");
      check("lost_dirty_miss", 32'(burst_q.size() - b0), 32'd1);

      repeat (4) @(posedge clk);
      check("outstanding_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/multi_line_buffer.md
Name: multi_line_buffer

Overview:
- Fully-associative write-back buffer of NUM_LINES lines of LINE_WORDS words each.
- Sits between a core-side SRAMx port and the cache bus ($Bus).
- Adds multi-line storage, round-robin replacement, configurable line length and an explicit flush (write back all dirty lines, then invalidate all).
- Hits complete in the request cycle; misses write back the victim if dirty, then refill with critical-word forwarding.

Parameters:
- NUM_LINES, 4, number of lines; power of two, 1..16.
- LINE_WORDS, 16, words per line; power of two, 2..16. Sets burst length and cbus order = log2(LINE_WORDS).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- sramx_req  input  sramx_req_t  core request: req, wr, size, addr[31:0], wdata
- sramx_resp  output  sramx_resp_t  addr_ok, data_ok, rdata[31:0]
- cbus_req  output  cbus_req_t  valid, is_write, order, addr[31:0], wdata
- cbus_resp  input  cbus_resp_t  okay, last, rdata
- flush_req  input  1  level; sampled only in IDLE
- flush_done  output  1  one-cycle pulse when a flush completes

Behaviour:
- Address split: align = addr[1:0]; offset = addr[OB+1:2], OB = log2(LINE_WORDS); tag = addr[31:OB+2]. Example: LINE_WORDS=16 gives a 26-bit tag.
- Per-line state: valid, dirty, tag, data. Global state: victim pointer (log2(NUM_LINES) bits), burst word counter (OB bits), saved request.
- Reset: all valid/dirty = 0, victim = 0, counter = 0, state = IDLE, flush_done = 0, cbus_req.valid = 0. Line data is not reset.
- States: IDLE, WRITEBACK, REFILL, FLUSH.
- IDLE:
  - addr_ok = 1.
  - Hit = any valid line with a matching tag; at most one line ever matches.
  - Hit: data_ok = 1 in the same cycle; rdata = line[offset].
  - Hit write: bytes merged per strobe from size/align; line marked dirty.
  - flush_req has priority over a same-cycle sramx_req. That request gets addr_ok = 0 and data_ok = 0 and is not accepted.
  - Miss: save the request. Go to WRITEBACK if line[victim] is valid and dirty, else to REFILL.
- WRITEBACK:
  - cbus valid = 1, is_write = 1, addr = {line[victim].tag, zeros}; wdata = line[victim][counter].
  - Counter increments on okay. On last, the counter has wrapped to 0; clear dirty, go to REFILL (or back to FLUSH).
- REFILL:
  - cbus valid = 1, is_write = 0, addr = {saved tag, zeros}.
  - Each okay writes rdata into line[victim][counter]. If counter == saved offset and the saved request is a write, strobed bytes come from the saved wdata instead.
  - data_ok = 1 in the cycle okay arrives with counter == saved offset; rdata = cbus_resp.rdata (forwarded).
  - On last: valid = 1, tag = saved tag, dirty = saved wr, victim = victim + 1 (wraps), go to IDLE.
- FLUSH:
  - Scan lines 0..NUM_LINES-1, one line index per cycle when not bursting.
  - A dirty line triggers a WRITEBACK burst, then the scan resumes at the next index.
  - After the last index: clear all valid bits, pulse flush_done, go to IDLE. Victim pointer is unchanged.
- addr_ok = 0 in all non-IDLE states. Exactly one data_ok per accepted request.
- cbus_req.valid stays asserted from entry of a burst through the last beat. order and addr stay stable within a burst.
- Reset mid-burst aborts it: cbus_req.valid drops next cycle and all line state is invalidated. Dirty data is lost by design.
- Back-to-back: a hit in the cycle after a refill's last beat is legal, including a hit on the just-filled line.

Test Plan:
- Defaults, read 0x0000_1008 cold -> REFILL burst at addr 0x0000_1000, order 4. data_ok on beat 2 with that beat's data; then read 0x0000_100C -> same-cycle data_ok from the buffer, no cbus activity.
- Miss-write sw 0xDEADBEEF to 0x2004 -> refill of 0x2000 with word 1 merged. A later lw 0x2004 returns 0xDEADBEEF; the line is dirty.
- Fill 5 distinct tags 0x1000, 0x2000, 0x3000, 0x4000, 0x5000 with line 0x1000 dirty. The fifth miss -> WRITEBACK of 0x1000 (16 beats, stored data), then REFILL of 0x5000; victim pointer = 1.
- sb 0xAB to 0x3002 on a hit line -> only byte 2 changes; lw returns e.g. 0x00AB0000 over zero data.
- flush_req with lines 1 and 3 dirty -> exactly two write bursts in index order, flush_done pulses once, and a subsequent read of any prior address misses. A same-cycle sramx_req gets addr_ok = 0.
- Assert reset during beat 7 of a REFILL -> cbus_req.valid = 0 next cycle; a re-read of the same address performs a full refill.
